mult_err_sweep: RTL

MULT_ERR_SWEEP -- requirements
Module: mult_err_sweep

---
 rtl/mult_err_sweep.sv | 97 +++++++++
 1 files changed

// File: rtl/mult_err_sweep.sv
// Exhaustive error characterization of an external combinational W x W multiplier.
// Sweeps every operand pair once (B inner, A outer), accumulating match count and error stats.
module mult_err_sweep #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_y,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   correct_cnt,
  output logic [31:0]    err_sum,
  output logic [2*W-1:0] max_err
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = 2 * W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     sum_q, sum_d;
  logic [PW-1:0]   max_q, max_d;
  logic [PW-1:0]   exact, err;
  logic            last;

  assign exact = PW'(a_q) * PW'(b_q);
  assign err   = (exact >= mul_y) ? (exact - mul_y) : (mul_y - exact);
  assign last  = (&a_q) & (&b_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    max_d   = max_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          a_d     = '0;
          b_d     = '0;
          cnt_d   = '0;
          sum_d   = '0;
          max_d   = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CW'(err == '0);
        sum_d = sum_q + 32'(err);
        if (err > max_q) max_d = err;
        b_d = b_q + W'(1);
        if (&b_q) a_d = a_q + W'(1);
        // Operands park on the final pair so the last evaluation stays observable.
        if (last) begin
          state_d = StDone;
          a_d     = a_q;
          b_d     = b_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
    end
  end

  assign mul_a       = a_q;
  assign mul_b       = b_q;
  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign correct_cnt = cnt_q;
  assign err_sum     = sum_q;
  assign max_err     = max_q;

endmodule
